quad_slot_mem_ctrl: RTL
=======================

# quad_slot_mem_ctrl

Time-division controller that shares one external single-port SRAM among four clients, such as video fetch, game logic, sprite engine and sound. Runs on `clk_100mhz` and uses the 2-bit phase count from the clock manager to give each client a fixed bus slot once every four cycles. Accesses are issued one per cycle with no arbitration logic. Also checks that the phase input advances cleanly and flags any discontinuity.

## Interface
Parameters:
- `ADDR_W`, 18, SRAM and client address width
- `DATA_W`, 16, SRAM and client data width

Ports:
- `clk_100mhz`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low; resets all state while low
- `clk_100mhz_phase`  in  2  free-running slot phase; expected to increment by 1 mod 4 every cycle
- `req`  in  4  per-client request level, bit i = client i
- `we`  in  4  per-client write enable, qualified by `req`
- `addr`  in  4*ADDR_W  client i address at bits [i*ADDR_W +: ADDR_W]
- `wdata`  in  4*DATA_W  client i write data, packed the same way
- `rdata`  out  4*DATA_W  client i read data, packed the same way
- `ack`  out  4  one-cycle completion pulse per client
- `mem_addr`  out  ADDR_W  SRAM address, registered
- `mem_wdata`  out  DATA_W  SRAM write data, registered
- `mem_we_n`  out  1  SRAM write strobe, registered, active-low
- `mem_oe_n`  out  1  SRAM output enable, registered, active-low
- `mem_rdata`  in  DATA_W  SRAM read data
- `phase_err`  out  1  sticky phase-discontinuity flag

## Operation
Slot ownership:
- Phase value i owns client i.
- At each rising edge, the controller samples `clk_100mhz_phase`. If the issue guard below holds and `req[i]` is high for the owning client i, it issues an access.

Issue, at edge E0:
- Load `mem_addr` from `addr[i]`.
- For a write (`we[i]`=1): load `mem_wdata` from `wdata[i]`, set `mem_we_n`=0 and `mem_oe_n`=1.
- For a read (`we[i]`=0): set `mem_oe_n`=0 and `mem_we_n`=1.
- Record owner i and a valid bit in the stage-B register.
- Idle slot: `mem_we_n`=`mem_oe_n`=1; `mem_addr` and `mem_wdata` hold their previous values.

Completion, at edge E1 (the end of the bus cycle):
- If stage B is valid, pulse `ack[owner]` for exactly one cycle.
- For a read, also load `rdata[owner]` from `mem_rdata`.
- Each `rdata[i]` holds its value until that client's next read completes. Writes do not change `rdata`.

Request protocol:
- `req` is a level signal. The client holds `req`, `we`, `addr` and `wdata` stable until it sees `ack`.
- If `req[i]` is still high at the next owned phase (E0+4), a new access is issued. This is legal and gives back-to-back accesses every 4 cycles.

Phase check:
- A `prev_valid` bit is cleared by reset and set after the first edge following reset release.
- When `prev_valid`=1 and the sampled phase differs from (previous phase + 1) mod 4, `phase_err` sets and stays set until reset.
- In that same cycle, issue is suppressed: the slot is forced idle and `req` is ignored.
- Any access already in stage B still completes normally.
- After a discontinuity, the new sequence is the reference for the next comparison.

Issue guard: issue occurs only when `prev_valid`=0 or the phase is in sequence.

Reset, while `reset` is low (asynchronous):
- `mem_we_n`=1, `mem_oe_n`=1, `mem_addr`=0, `mem_wdata`=0
- `ack`=0, `rdata`=0 for all clients, `phase_err`=0
- Stage B invalid, `prev_valid`=0
- A mid-access reset drops the in-flight access: no `ack` is produced and the strobes deassert immediately.

## Timing
- Latency: `req[i]` sampled at E0 (phase==i); SRAM strobes active for the cycle E0 to E1; `ack[i]` and `rdata[i]` valid in the cycle after E1 (2 edges after sampling).
- `mem_rdata` is sampled at E1. The SRAM access time must fit within one `clk_100mhz` period minus output-register and input-setup delays.
- Throughput: one access per cycle across all clients; at most one per 4 cycles per client.
- `ack[i]` is high from E1 to E2. The client must drop `req[i]` before E4 to avoid a repeat access.
- The issue decision is a function of the sampled phase only; no cross-slot priority exists.

## Test plan
- Single read: preload SRAM model address 0x00010 with 0xBEEF; client 2 `req`=1, `we`=0 at phase 2 → `mem_oe_n`=0 with `mem_addr`=0x00010 for one cycle; `ack[2]` pulses 2 edges later; `rdata[2]`=0xBEEF.
- Write then read back: client 0 writes 0x1234 to 0x3FFFF, then reads the same address → one cycle with `mem_we_n`=0 and `mem_wdata`=0x1234; the later read returns 0x1234; `rdata[0]` is unchanged by the write.
- All four clients requesting continuously → exactly one access per cycle in slot order 0,1,2,3; each `ack` fires once per 4 cycles; no two strobes are active in the same cycle.
- Phase jump: sequence 0,1,3,0 with all `req` high → `phase_err`=1 from the edge sampling 3; no access issued for that sample; the access sampled at phase 1 still acks; access resumes at the following 0.
- Reset mid-access: assert `reset` low between E0 and E1 of a read → strobes return to 1 immediately; no `ack`; all `rdata`=0; `phase_err`=0.
- Idle: `req`=0 → `mem_we_n`=`mem_oe_n`=1 continuously; `ack` never pulses.

Source files
------------

// File: rtl/quad_slot_mem_ctrl.sv
// Time-division SRAM controller: four clients share one single-port SRAM, each owning
// one phase of a free-running 2-bit slot counter. Discontinuities in the phase are flagged.
module quad_slot_mem_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic                clk_100mhz,
  input  logic                reset,
  input  logic [1:0]          clk_100mhz_phase,
  input  logic [3:0]          req,
  input  logic [3:0]          we,
  input  logic [4*ADDR_W-1:0] addr,
  input  logic [4*DATA_W-1:0] wdata,
  output logic [4*DATA_W-1:0] rdata,
  output logic [3:0]          ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we_n,
  output logic                mem_oe_n,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                phase_err
);

  logic [1:0]        prev_phase_r;
  logic              prev_valid_r;
  logic              phase_err_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_we_n_r;
  logic              mem_oe_n_r;
  logic              b_valid_r;
  logic [1:0]        b_owner_r;
  logic              b_read_r;
  logic [3:0]        ack_r;
  logic [DATA_W-1:0] rdata_r [4];

  logic              in_seq_s;
  logic              jump_s;
  logic              issue_s;
  logic              slot_req_s;
  logic              slot_we_s;
  logic [ADDR_W-1:0] slot_addr_s;
  logic [DATA_W-1:0] slot_wdata_s;

  // Select the request fields of the client that owns the sampled phase.
  always_comb begin
    slot_req_s   = 1'b0;
    slot_we_s    = 1'b0;
    slot_addr_s  = {ADDR_W{1'b0}};
    slot_wdata_s = {DATA_W{1'b0}};
    case (clk_100mhz_phase)
      2'd0: begin
        slot_req_s   = req[0];
        slot_we_s    = we[0];
        slot_addr_s  = addr[0*ADDR_W +: ADDR_W];
        slot_wdata_s = wdata[0*DATA_W +: DATA_W];
      end
      2'd1: begin
        slot_req_s   = req[1];
        slot_we_s    = we[1];
        slot_addr_s  = addr[1*ADDR_W +: ADDR_W];
        slot_wdata_s = wdata[1*DATA_W +: DATA_W];
      end
      2'd2: begin
        slot_req_s   = req[2];
        slot_we_s    = we[2];
        slot_addr_s  = addr[2*ADDR_W +: ADDR_W];
        slot_wdata_s = wdata[2*DATA_W +: DATA_W];
      end
      2'd3: begin
        slot_req_s   = req[3];
        slot_we_s    = we[3];
        slot_addr_s  = addr[3*ADDR_W +: ADDR_W];
        slot_wdata_s = wdata[3*DATA_W +: DATA_W];
      end
      default: begin
        slot_req_s   = 1'b0;
        slot_we_s    = 1'b0;
        slot_addr_s  = {ADDR_W{1'b0}};
        slot_wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Phase continuity and issue guard; a broken sequence forces the slot idle.
  always_comb begin
    in_seq_s = (clk_100mhz_phase == (prev_phase_r + 2'd1));
    if (prev_valid_r && !in_seq_s) begin
      jump_s = 1'b1;
    end else begin
      jump_s = 1'b0;
    end
    if (!jump_s && slot_req_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Phase history and sticky discontinuity flag.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      prev_phase_r <= 2'd0;
      prev_valid_r <= 1'b0;
      phase_err_r  <= 1'b0;
    end else begin
      prev_phase_r <= clk_100mhz_phase;
      prev_valid_r <= 1'b1;
      if (jump_s) begin
        phase_err_r <= 1'b1;
      end
    end
  end

  // Issue stage: drive the SRAM bus and record the owner in stage B.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_we_n_r  <= 1'b1;
      mem_oe_n_r  <= 1'b1;
      b_valid_r   <= 1'b0;
      b_owner_r   <= 2'd0;
      b_read_r    <= 1'b0;
    end else if (issue_s) begin
      mem_addr_r <= slot_addr_s;
      b_valid_r  <= 1'b1;
      b_owner_r  <= clk_100mhz_phase;
      b_read_r   <= !slot_we_s;
      if (slot_we_s) begin
        mem_wdata_r <= slot_wdata_s;
        mem_we_n_r  <= 1'b0;
        mem_oe_n_r  <= 1'b1;
      end else begin
        mem_we_n_r <= 1'b1;
        mem_oe_n_r <= 1'b0;
      end
    end else begin
      mem_we_n_r <= 1'b1;
      mem_oe_n_r <= 1'b1;
      b_valid_r  <= 1'b0;
    end
  end

  // Completion stage: acknowledge the owner and capture read data at the end of the bus cycle.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      ack_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        rdata_r[i] <= {DATA_W{1'b0}};
      end
    end else if (b_valid_r) begin
      ack_r <= 4'b0001 << b_owner_r;
      if (b_read_r) begin
        rdata_r[b_owner_r] <= mem_rdata;
      end
    end else begin
      ack_r <= 4'b0000;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_rdata
    assign rdata[g*DATA_W +: DATA_W] = rdata_r[g];
  end

  assign ack       = ack_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we_n  = mem_we_n_r;
  assign mem_oe_n  = mem_oe_n_r;
  assign phase_err = phase_err_r;

  quad_slot_mem_ctrl_chk u_chk (
    .clk      (clk_100mhz),
    .rst_n    (reset),
    .mem_we_n (mem_we_n_r),
    .mem_oe_n (mem_oe_n_r),
    .ack      (ack_r)
  );

endmodule

// Bus-protocol properties: the SRAM never sees both strobes at once, and at most one ack fires.
module quad_slot_mem_ctrl_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       mem_we_n,
  input logic       mem_oe_n,
  input logic [3:0] ack
);

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(!mem_we_n && !mem_oe_n));
  a_ack_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));

endmodule
